sign_narrow: RTL and testbench

Writeback-side companion to the immediate sign extender. It converts signed 6-bit datapath results back to the 4-bit signed constant format for the register file and constant store, using saturation or two's-complement wrap. It has valid/ready handshakes on both sides, a 2-entry skid buffer and a sticky saturating overflow counter. It sits between the ALU result stage and the narrow writeback port.

---
 rtl/sign_narrow.sv | 125 ++++++++++++
 tb/tb_sign_narrow.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sign_narrow.sv
// rtl/sign_narrow.sv - narrows signed IN_W results to signed OUT_W (saturate or wrap)
// with a valid/ready output register, 2-entry skid buffer and sticky overflow counter.
module sign_narrow #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             VALID_I,
  output logic             READY_O,
  input  logic [IN_W-1:0]  DATA_I,
  input  logic             MODE_I,
  output logic             VALID_O,
  input  logic             READY_I,
  output logic [OUT_W-1:0] DATA_O,
  output logic             OVF_O,
  output logic [CNT_W-1:0] OVF_CNT_O,
  input  logic             CLR_CNT_I
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                state, state_nxt;
  logic [IN_W-OUT_W:0]   top_bits;
  logic                  ovf;
  logic [OUT_W-1:0]      narrow;
  logic                  accept, emit;
  logic                  load_or_in, load_or_sk, load_sk;
  logic [OUT_W-1:0]      sk_data;
  logic                  sk_ovf;

  // In range exactly when the dropped bits all replicate the new sign bit.
  assign top_bits = DATA_I[IN_W-1:OUT_W-1];
  assign ovf      = ~((&top_bits) | ~(|top_bits));

  always_comb begin
    narrow = DATA_I[OUT_W-1:0];
    if (ovf && !MODE_I) begin
      narrow = DATA_I[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  assign accept = VALID_I & READY_O;
  assign emit   = VALID_O & READY_I;

  always_comb begin
    state_nxt  = state;
    load_or_in = 1'b0;
    load_or_sk = 1'b0;
    load_sk    = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_or_in = 1'b1;
          state_nxt  = FULL;
        end
      end
      FULL: begin
        if (accept && emit) begin
          load_or_in = 1'b1;
        end else if (accept) begin
          load_sk   = 1'b1;
          state_nxt = SKID;
        end else if (emit) begin
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (emit) begin
          load_or_sk = 1'b1;
          state_nxt  = FULL;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // READY_O/VALID_O are registered from the next state so neither
  // depends combinationally on READY_I.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= EMPTY;
      READY_O <= 1'b1;
      VALID_O <= 1'b0;
      DATA_O  <= '0;
      OVF_O   <= 1'b0;
      sk_data <= '0;
      sk_ovf  <= 1'b0;
    end else begin
      state   <= state_nxt;
      READY_O <= (state_nxt != SKID);
      VALID_O <= (state_nxt != EMPTY);
      if (load_or_in) begin
        DATA_O <= narrow;
        OVF_O  <= ovf;
      end else if (load_or_sk) begin
        DATA_O <= sk_data;
        OVF_O  <= sk_ovf;
      end
      if (load_sk) begin
        sk_data <= narrow;
        sk_ovf  <= ovf;
      end
    end
  end

  // Counter counts at accept; a clear coinciding with an overflow leaves 1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVF_CNT_O <= '0;
    end else if (accept && ovf) begin
      if (CLR_CNT_I) begin
        OVF_CNT_O <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (OVF_CNT_O != CNT_MAX) begin
        OVF_CNT_O <= OVF_CNT_O + 1'b1;
      end
    end else if (CLR_CNT_I) begin
      OVF_CNT_O <= '0;
    end
  end

endmodule

// File: tb/tb_sign_narrow.sv
// tb/tb_sign_narrow.sv - directed vector table plus hand-written handshake and counter sequences.
module tb_sign_narrow;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       VALID_I = 1'b0;
  logic       READY_O;
  logic [5:0] DATA_I = '0;
  logic       MODE_I = 1'b0;
  logic       VALID_O;
  logic       READY_I = 1'b0;
  logic [3:0] DATA_O;
  logic       OVF_O;
  logic [7:0] OVF_CNT_O;
  logic       CLR_CNT_I = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [5:0] data;
    logic       mode;
    logic [3:0] exp_data;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[14];

  sign_narrow #(.IN_W(6), .OUT_W(4), .CNT_W(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .VALID_I   (VALID_I),
    .READY_O   (READY_O),
    .DATA_I    (DATA_I),
    .MODE_I    (MODE_I),
    .VALID_O   (VALID_O),
    .READY_I   (READY_I),
    .DATA_O    (DATA_O),
    .OVF_O     (OVF_O),
    .OVF_CNT_O (OVF_CNT_O),
    .CLR_CNT_I (CLR_CNT_I)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{6'b000101, 1'b0, 4'b0101, 1'b0};
    vecs[1]  = '{6'b111101, 1'b0, 4'b1101, 1'b0};
    vecs[2]  = '{6'b011001, 1'b0, 4'b0111, 1'b1};
    vecs[3]  = '{6'b100011, 1'b0, 4'b1000, 1'b1};
    vecs[4]  = '{6'b011001, 1'b1, 4'b1001, 1'b1};
    vecs[5]  = '{6'b000111, 1'b1, 4'b0111, 1'b0};
    vecs[6]  = '{6'b111000, 1'b1, 4'b1000, 1'b0};
    vecs[7]  = '{6'b001000, 1'b1, 4'b1000, 1'b1};
    vecs[8]  = '{6'b001000, 1'b0, 4'b0111, 1'b1};
    vecs[9]  = '{6'b110111, 1'b0, 4'b1000, 1'b1};
    vecs[10] = '{6'b110111, 1'b1, 4'b0111, 1'b1};
    vecs[11] = '{6'b011111, 1'b0, 4'b0111, 1'b1};
    vecs[12] = '{6'b100000, 1'b1, 4'b0000, 1'b1};
    vecs[13] = '{6'b000111, 1'b0, 4'b0111, 1'b0};

    // Reset state
    #12;
    chk("rst_valid", VALID_O, 0);
    chk("rst_ready", READY_O, 1);
    chk("rst_data", DATA_O, 0);
    chk("rst_cnt", OVF_CNT_O, 0);
    RST_N = 1'b1;
    READY_I = 1'b1;

    // Single beats with READY_I high
    @(posedge CLK); #1;
    foreach (vecs[i]) begin
      VALID_I = 1'b1;
      DATA_I  = vecs[i].data;
      MODE_I  = vecs[i].mode;
      @(posedge CLK); #1;
      VALID_I = 1'b0;
      DATA_I  = 6'b011111;
      MODE_I  = 1'b0;
      if (vecs[i].exp_ovf) exp_cnt++;
      @(negedge CLK);
      chk($sformatf("vec%0d_valid", i), VALID_O, 1);
      chk($sformatf("vec%0d_data", i), DATA_O, vecs[i].exp_data);
      chk($sformatf("vec%0d_ovf", i), OVF_O, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_cnt", i), OVF_CNT_O, exp_cnt);
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_drain", i), VALID_O, 0);
    end

    // Backpressure: beats 1..4 with READY_I low
    READY_I = 1'b0;
    MODE_I  = 1'b0;
    VALID_I = 1'b1;
    DATA_I  = 6'd1;
    @(posedge CLK); #1;
    DATA_I = 6'd2;
    @(negedge CLK);
    chk("bp_ready_full", READY_O, 1);
    @(posedge CLK); #1;
    DATA_I = 6'd3;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("bp_ready_skid", READY_O, 0);
    chk("bp_valid", VALID_O, 1);
    chk("bp_hold_data", DATA_O, 1);
    chk("bp_cnt", OVF_CNT_O, exp_cnt);
    READY_I = 1'b1;
    @(posedge CLK); #1;
    chk("bp_ready_back", READY_O, 1);
    chk("bp_out2", DATA_O, 2);
    @(posedge CLK); #1;
    DATA_I = 6'd4;
    chk("bp_out3", DATA_O, 3);
    @(posedge CLK); #1;
    VALID_I = 1'b0;
    chk("bp_out4", DATA_O, 4);
    chk("bp_out4_valid", VALID_O, 1);
    @(posedge CLK); #1;
    chk("bp_drained", VALID_O, 0);

    // Async reset while holding two beats, counter nonzero
    READY_I = 1'b0;
    VALID_I = 1'b1;
    DATA_I  = 6'b011001;
    repeat (2) @(posedge CLK);
    #1;
    VALID_I = 1'b0;
    chk("pre_rst_ready", READY_O, 0);
    chk("pre_rst_cnt", OVF_CNT_O, exp_cnt + 2);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_valid", VALID_O, 0);
    chk("arst_ready", READY_O, 1);
    chk("arst_data", DATA_O, 0);
    chk("arst_ovf", OVF_O, 0);
    chk("arst_cnt", OVF_CNT_O, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    READY_I = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_valid", VALID_O, 0);

    // Counter saturation and clear
    VALID_I = 1'b1;
    DATA_I  = 6'b100011;
    MODE_I  = 1'b1;
    repeat (254) @(posedge CLK);
    #1;
    chk("cnt_254", OVF_CNT_O, 254);
    @(posedge CLK); #1;
    chk("cnt_255", OVF_CNT_O, 255);
    @(posedge CLK); #1;
    chk("cnt_sat", OVF_CNT_O, 255);
    chk("cnt_beat_data", DATA_O, 4'b0011);
    CLR_CNT_I = 1'b1;
    @(posedge CLK); #1;
    chk("cnt_clr_ovf", OVF_CNT_O, 1);
    VALID_I = 1'b0;
    @(posedge CLK); #1;
    chk("cnt_clr", OVF_CNT_O, 0);
    CLR_CNT_I = 1'b0;
    VALID_I = 1'b1;
    DATA_I  = 6'b000011;
    @(posedge CLK); #1;
    VALID_I = 1'b0;
    chk("cnt_no_ovf", OVF_CNT_O, 0);
    chk("cnt_no_ovf_flag", OVF_O, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
